rtl_simple_algo_stream_fifo: RTL and testbench

Elastic output buffer directly downstream of the HLS SIMD adder blackbox stage. Captures the 11-bit `z`/`z_write` result stream into a small circular FIFO and re-presents it on an HLS `ap_fifo`-style read interface (`dout`/`empty_n`/`read`) for the next HLS consumer. The upstream adder stage does not honour backpressure, so writes arriving while the FIFO is full are dropped. Those drops are counted when the count feature is compiled in.

---
 rtl/rtl_simple_algo_stream_fifo.sv | 82 ++++++++
 tb/tb_rtl_simple_algo_stream_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rtl_simple_algo_stream_fifo.sv
// Elastic FWFT buffer that turns the adder's z/z_write stream into an ap_fifo read port.
// Optional dropped-write counter is enabled with `define STREAM_FIFO_DROP_CNT_EN.
module rtl_simple_algo_stream_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          ap_ce,
  input  logic [DW-1:0] din,
  input  logic          din_write,
  output logic          din_full_n,
  output logic [DW-1:0] dout,
  output logic          dout_empty_n,
  input  logic          dout_read,
  output logic [AW:0]   count
`ifdef STREAM_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic          not_full;
  logic          not_empty;

  // Handshake: a write transfers on a clock-enabled edge where din_write=1 and
  // din_full_n=1; a read transfers where dout_read=1 and dout_empty_n=1. The
  // producer ignores din_full_n, so a write offered while full is dropped.
  // Both flags come from the registered count only, so a same-cycle pop never
  // makes room for a write.
  assign not_full  = (count != FULL_CNT);
  assign not_empty = (count != '0);
  assign wr_acc    = ap_ce & din_write & not_full;
  assign rd_acc    = ap_ce & dout_read & not_empty;

  assign din_full_n   = not_full;
  assign dout_empty_n = not_empty;
  assign dout         = not_empty ? mem[rd_ptr] : '0;

  // Storage is not reset; reset only blocks writes so held data is unaffected.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst && wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the natural AW-bit rollover is the wrap.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef STREAM_FIFO_DROP_CNT_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      drop_cnt <= '0;
    end else if (ap_ce && din_write && !not_full && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rtl_simple_algo_stream_fifo.sv
// Directed bench for rtl_simple_algo_stream_fifo: expected-data queue popped by a read monitor,
// plus hand-computed occupancy/flag checks. Drop counter checks exist when STREAM_FIFO_DROP_CNT_EN is set.
module tb_rtl_simple_algo_stream_fifo;

  localparam int DW    = 11;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          ap_ce;
  logic [DW-1:0] din;
  logic          din_write;
  logic          din_full_n;
  logic [DW-1:0] dout;
  logic          dout_empty_n;
  logic          dout_read;
  logic [AW:0]   count;
`ifdef STREAM_FIFO_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];
  int m_cnt = 0;

  rtl_simple_algo_stream_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .ap_ce        (ap_ce),
    .din          (din),
    .din_write    (din_write),
    .din_full_n   (din_full_n),
    .dout         (dout),
    .dout_empty_n (dout_empty_n),
    .dout_read    (dout_read),
    .count        (count)
`ifdef STREAM_FIFO_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  // clock / reset
  always #5 ap_clk = ~ap_clk;

  // monitor: every read the DUT will accept at the next edge is checked here
  always @(negedge ap_clk) begin
    if (!ap_rst && ap_ce && dout_read && dout_empty_n) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: dout=%h, required no data", dout);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          fails++;
          $display("FAIL pop_data: dout=%h, required %h", dout, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // driver: one clock cycle with the given strobes; queue push on expected acceptance
  task automatic cycle(input logic we, input logic [DW-1:0] d, input logic re, input logic ce);
    @(posedge ap_clk);
    #1;
    ap_rst    = 1'b0;
    ap_ce     = ce;
    din_write = we;
    din       = d;
    dout_read = re;
    if (ce) begin
      logic wa, ra;
      wa = we && (m_cnt != DEPTH);
      ra = re && (m_cnt != 0);
      if (wa) exp_q.push_back(d);
      m_cnt = m_cnt + int'(wa) - int'(ra);
    end
    @(negedge ap_clk);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input logic we, input logic [DW-1:0] d);
    @(posedge ap_clk);
    #1;
    ap_rst    = 1'b1;
    ap_ce     = 1'b1;
    din_write = we;
    din       = d;
    dout_read = 1'b1;
    exp_q.delete();
    m_cnt = 0;
    @(negedge ap_clk);
  endtask

  initial begin
    ap_rst = 1'b1; ap_ce = 1'b0; din = '0; din_write = 1'b0; dout_read = 1'b0;
    do_reset(1'b0, '0);
    do_reset(1'b1, 11'h5A5);
    idle();
    chk("rst_dout", dout, 0);
    chk("rst_empty_n", dout_empty_n, 0);
    chk("rst_full_n", din_full_n, 1);
    chk("rst_count", count, 0);
`ifdef STREAM_FIFO_DROP_CNT_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif

    // fill with 001..008
    for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b0, 1'b1);
    idle();
    chk("fill_count", count, 8);
    chk("fill_full_n", din_full_n, 0);
    chk("fill_empty_n", dout_empty_n, 1);
    chk("fill_head", dout, 11'h001);

    // overflow: three dropped writes
    for (int i = 0; i < 3; i++) cycle(1'b1, 11'h7FF, 1'b0, 1'b1);
    idle();
    chk("ovf_count", count, 8);
    chk("ovf_head", dout, 11'h001);
`ifdef STREAM_FIFO_DROP_CNT_EN
    chk("ovf_drop_cnt", drop_cnt, 3);
`endif

    // drain 8: monitor checks 001..008 in order
    cycle(1'b0, '0, 1'b1, 1'b1);
    idle();
    chk("first_pop_full_n", din_full_n, 1);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    idle();
    chk("drain_empty_n", dout_empty_n, 0);
    chk("drain_count", count, 0);
    chk("drain_dout", dout, 0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    idle();
    chk("read_empty_count", count, 0);

    // empty with read+write: write taken, read ignored
    cycle(1'b1, 11'h00F, 1'b1, 1'b1);
    idle();
    chk("empty_rw_count", count, 1);
    chk("empty_rw_dout", dout, 11'h00F);

    // bring to 4, then 20 cycles of read+write across pointer wrap
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(11'h010 + i), 1'b0, 1'b1);
    idle();
    chk("pre_stream_count", count, 4);
    for (int i = 0; i < 20; i++) cycle(1'b1, DW'(11'h020 + i), 1'b1, 1'b1);
    idle();
    chk("stream_count", count, 4);
    chk("stream_head", dout, 11'h030);

    // fill to 8, then read+write while full: write dropped
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(11'h040 + i), 1'b0, 1'b1);
    idle();
    chk("refill_count", count, 8);
    cycle(1'b1, 11'h055, 1'b1, 1'b1);
    idle();
    chk("full_rw_count", count, 7);
    chk("full_rw_full_n", din_full_n, 1);
    chk("full_rw_head", dout, 11'h031);
`ifdef STREAM_FIFO_DROP_CNT_EN
    chk("full_rw_drop_cnt", drop_cnt, 4);
`endif

    // clock enable low: strobes ignored
    for (int i = 0; i < 5; i++) cycle(1'b1, 11'h3C3, 1'b1, 1'b0);
    idle();
    chk("ce_count", count, 7);
    chk("ce_head", dout, 11'h031);
    chk("ce_empty_n", dout_empty_n, 1);
    chk("ce_full_n", din_full_n, 1);
`ifdef STREAM_FIFO_DROP_CNT_EN
    chk("ce_drop_cnt", drop_cnt, 4);
`endif

    // down to 5, reset with a concurrent write
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    idle();
    chk("pre_rst_count", count, 5);
    do_reset(1'b1, 11'h3AA);
    idle();
    chk("midrst_count", count, 0);
    chk("midrst_empty_n", dout_empty_n, 0);
    chk("midrst_dout", dout, 0);
    cycle(1'b1, 11'h123, 1'b0, 1'b1);
    idle();
    chk("post_rst_dout", dout, 11'h123);
    chk("post_rst_empty_n", dout_empty_n, 1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    idle();
    chk("final_count", count, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
